// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width, op encodings and the
// output-buffer state type used by the round-robin ALU arbiter.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_SLT  = 3'b110,
        OP_NOR  = 3'b111
    } alu_op_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/alu32_core.sv
// Combinational ALU datapath. Logic ops are built from the shared gate
// modules; the inverted forms (xnor, nor) reuse the xor/or gate outputs.
module alu32_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] xor_s;
    logic             slt_s;

    and_gate32 #(.WIDTH(WIDTH)) u_and (.a_i(x), .b_i(y), .y_o(and_s));
    or_gate32  #(.WIDTH(WIDTH)) u_or  (.a_i(x), .b_i(y), .y_o(or_s));
    xor_gate32 #(.WIDTH(WIDTH)) u_xor (.a_i(x), .b_i(y), .y_o(xor_s));

    assign slt_s = ($signed(x) < $signed(y)) ? 1'b1 : 1'b0;

    // Select the result of the requested operation; add/sub wrap naturally.
    always_comb begin
        out = {WIDTH{1'b0}};
        case (alu_op_e'(op))
            OP_AND:  out = and_s;
            OP_OR:   out = or_s;
            OP_XOR:  out = xor_s;
            OP_XNOR: out = ~xor_s;
            OP_ADD:  out = x + y;
            OP_SUB:  out = x - y;
            OP_SLT:  out = {{(WIDTH-1){1'b0}}, slt_s};
            OP_NOR:  out = ~or_s;
            default: out = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_gates.sv
// Bitwise gate building blocks shared by the ALU datapath.
module and_gate32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i & b_i;
endmodule

module or_gate32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i | b_i;
endmodule

module xor_gate32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i ^ b_i;
endmodule

// File: rtl/alu_rr_arbiter.sv
// Two requesters share one ALU through a one-entry registered result
// buffer. Contention is resolved round-robin by a 1-bit pointer that
// always points away from the most recently granted requester.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_out,
    output logic             res_id
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] res_out_q, res_out_d;
    logic             res_id_q, res_id_d;
    logic             ptr_q, ptr_d;

    logic             accept_s;
    logic             grant_s;
    logic             grant_idx_s;
    logic [2:0]       op_s;
    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] alu_out_s;

    // Arbitration: pick a winner and raise only its ready (never during reset).
    always_comb begin
        accept_s = (state_q == BUF_EMPTY) || res_ready;
        if (req0_valid && req1_valid) begin
            grant_idx_s = ptr_q;
        end else begin
            grant_idx_s = req1_valid;
        end
        grant_s    = !rst && accept_s && (req0_valid || req1_valid);
        req0_ready = grant_s && !grant_idx_s;
        req1_ready = grant_s && grant_idx_s;
    end

    // Steer only the granted requester's operands into the ALU.
    always_comb begin
        if (grant_idx_s) begin
            op_s = req1_op;
            x_s  = req1_x;
            y_s  = req1_y;
        end else begin
            op_s = req0_op;
            x_s  = req0_x;
            y_s  = req0_y;
        end
    end

    alu32_core #(.WIDTH(WIDTH)) u_core (
        .op  (op_s),
        .x   (x_s),
        .y   (y_s),
        .out (alu_out_s)
    );

    // Buffer next state: load on transfer (also drain+refill), else drain or hold.
    always_comb begin
        state_d   = state_q;
        res_out_d = res_out_q;
        res_id_d  = res_id_q;
        ptr_d     = ptr_q;
        if (grant_s) begin
            state_d   = BUF_FULL;
            res_out_d = alu_out_s;
            res_id_d  = grant_idx_s;
            ptr_d     = !grant_idx_s;
        end else if ((state_q == BUF_FULL) && res_ready) begin
            state_d = BUF_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Buffer and pointer registers; reset drops any undelivered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BUF_EMPTY;
            res_out_q <= {WIDTH{1'b0}};
            res_id_q  <= 1'b0;
            ptr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_out_q <= res_out_d;
            res_id_q  <= res_id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign res_valid = (state_q == BUF_FULL);
    assign res_out   = res_out_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with hand-computed expected values.
module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic        res_valid, res_ready, res_id;
    logic [31:0] res_out;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_out    (res_out),
        .res_id     (res_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic v, input logic [31:0] o, input logic id);
        check({tag, ".valid"}, {31'd0, res_valid}, {31'd0, v});
        check({tag, ".out"}, res_out, o);
        check({tag, ".id"}, {31'd0, res_id}, {31'd0, id});
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, ".rdy0"}, {31'd0, req0_ready}, {31'd0, r0});
        check({tag, ".rdy1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    initial begin
        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b000; req0_x = 32'd0; req0_y = 32'd0;
        req1_valid = 1'b1; req1_op = 3'b000; req1_x = 32'd0; req1_y = 32'd0;
        #1;
        check_rdy("rst_hold", 1'b0, 1'b0);
        tick();
        tick();
        check_res("reset", 1'b0, 32'h0000_0000, 1'b0);
        check_rdy("rst_hold2", 1'b0, 1'b0);

        // Single requester xnor
        rst = 1'b0; req1_valid = 1'b0;
        req0_op = 3'b011; req0_x = 32'hFFFF_0000; req0_y = 32'hFF00_FF00;
        #1;
        check_rdy("single", 1'b1, 1'b0);
        tick();
        check_res("xnor", 1'b1, 32'hFF00_00FF, 1'b0);
        req0_valid = 1'b0;
        tick();
        check_res("drain", 1'b0, 32'hFF00_00FF, 1'b0);

        // Reset to restore pointer, then contention
        rst = 1'b1; tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b100; req0_x = 32'd1;    req0_y = 32'd2;
        req1_valid = 1'b1; req1_op = 3'b010; req1_x = 32'hF0;   req1_y = 32'hFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_rdy($sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
            check_res($sformatf("cont%0d", i), 1'b1,
                      ((i % 2) == 1) ? 32'h0000_000F : 32'h0000_0003, (i % 2) == 1);
        end

        // Backpressure: buffer holds id1 result, pointer back at req0
        res_ready = 1'b0;
        req0_x = 32'd100;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
            tick();
            check_res($sformatf("bp%0d", i), 1'b1, 32'h0000_000F, 1'b1);
        end
        res_ready = 1'b1;
        #1;
        check_rdy("release", 1'b1, 1'b0);
        tick();
        check_res("release", 1'b1, 32'h0000_0066, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check_res("empty", 1'b0, 32'h0000_0066, 1'b0);

        // Arithmetic wrap on requester 1; requester 0 carries ignored junk
        req0_op = 3'b001; req0_x = 32'hDEAD_BEEF; req0_y = 32'h1234_5678;
        req1_valid = 1'b1; req1_op = 3'b100; req1_x = 32'hFFFF_FFFF; req1_y = 32'd1;
        tick();
        check_res("add_wrap", 1'b1, 32'h0000_0000, 1'b1);
        req1_op = 3'b110; req1_x = 32'h8000_0000; req1_y = 32'd0;
        tick();
        check_res("slt_neg", 1'b1, 32'h0000_0001, 1'b1);
        req1_op = 3'b101; req1_x = 32'd0; req1_y = 32'd1;
        tick();
        check_res("sub_wrap", 1'b1, 32'hFFFF_FFFF, 1'b1);

        // Remaining ops on requester 0, back-to-back
        req1_valid = 1'b0; req0_valid = 1'b1;
        req0_op = 3'b000; req0_x = 32'h0000_F0F0; req0_y = 32'h0000_FF00;
        tick();
        check_res("and", 1'b1, 32'h0000_F000, 1'b0);
        req0_op = 3'b001;
        tick();
        check_res("or", 1'b1, 32'h0000_FFF0, 1'b0);
        req0_op = 3'b110; req0_x = 32'd5; req0_y = 32'd3;
        tick();
        check_res("slt_false", 1'b1, 32'h0000_0000, 1'b0);
        req0_op = 3'b111; req0_x = 32'h0000_F0F0; req0_y = 32'h0000_FF00;
        tick();
        check_res("nor", 1'b1, 32'hFFFF_000F, 1'b0);

        // Reset while FULL (pointer currently at req1)
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0; rst = 1'b1;
        #1;
        check_rdy("rst_mid", 1'b0, 1'b0);
        tick();
        check_res("rst_mid", 1'b0, 32'h0000_0000, 1'b0);
        rst = 1'b0; res_ready = 1'b1;
        req0_op = 3'b100; req0_x = 32'd7; req0_y = 32'd8;
        #1;
        check_rdy("post_rst", 1'b1, 1'b0);
        tick();
        check_res("post_rst", 1'b1, 32'h0000_000F, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
- REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
- REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
- REQ-004 SHALL have ports: req0_valid  input  1; req0_ready  output  1; req0_op  input  3; req0_x  input  WIDTH; req0_y  input  WIDTH. These form requester 0.
- REQ-005 SHALL have ports: req1_valid  input  1; req1_ready  output  1; req1_op  input  3; req1_x  input  WIDTH; req1_y  input  WIDTH. These form requester 1.
- REQ-006 SHALL have ports: res_valid  output  1; res_ready  input  1; res_out  output  WIDTH, result; res_id  output  1, index of the requester that owns res_out.

Function
- REQ-007 SHALL share one combinational ALU between two requesters through a one-entry registered output buffer; states EMPTY (res_valid=0) and FULL (res_valid=1).
- REQ-008 SHALL use this op encoding: 000 and; 001 or; 010 xor; 011 xnor; 100 add, mod 2^WIDTH; 101 sub x-y, mod 2^WIDTH; 110 signed slt, result 1 or 0 zero-extended; 111 nor.
- REQ-009 SHALL define accept = !res_valid || res_ready, evaluated every cycle.
- REQ-010 SHALL grant at most one requester per cycle, and only when accept=1 and at least one reqN_valid=1.
- REQ-011 SHALL resolve contention round-robin with a 1-bit priority pointer: when both requesters are valid, grant the pointer's index; after any grant, pointer = !granted index.
- REQ-012 SHALL, when exactly one requester is valid, grant that requester regardless of pointer, and update the pointer per REQ-011.
- REQ-013 SHALL drive reqN_ready combinationally high only for the granted requester; a transfer occurs when reqN_valid && reqN_ready.
- REQ-014 SHALL NOT let reqN_ready depend on the other requester's ready output.
- REQ-015 SHALL register the ALU result and requester index on transfer; res_valid rises on the next edge, giving latency = 1 cycle.
- REQ-016 SHALL hold res_out and res_id stable while res_valid=1 and res_ready=0.
- REQ-017 SHALL support drain and refill in the same cycle when FULL, res_ready=1 and a requester is valid: the new result loads, res_valid stays 1, and throughput is 1 result/cycle.
- REQ-018 SHALL, when FULL and res_ready=1 with no valid requester, go to EMPTY; res_out keeps its last value.
- REQ-019 SHALL ignore op/x/y of any requester that is not granted.

Reset
- REQ-020 SHALL, with rst=1 at a clock edge, set res_valid=0, res_out=0, res_id=0 and pointer=0 (requester 0 first).
- REQ-021 SHALL drive req0_ready=0 and req1_ready=0 while rst=1.
- REQ-022 SHALL discard any buffered, undelivered result when reset is asserted mid-operation; the result is not replayed.

Structure
- REQ-023 SHALL take the op encoding constants and the default WIDTH from the shared package alu_pkg.
- REQ-024 SHALL instantiate the combinational datapath as one sub-module, alu32_core (inputs op, x, y; output out), which reuses the existing 32-bit bitwise gate modules.
- REQ-025 SHALL keep the arbitration, handshake and buffer logic in alu_rr_arbiter only.

Verification
- REQ-026 SHALL cover single requester: req0 op=011, x=0xFFFF0000, y=0xFF00FF00, res_ready=1 -> next cycle res_valid=1, res_out=0xFF0000FF, res_id=0.
- REQ-027 SHALL cover contention: both requesters valid for 4 cycles after reset, res_ready=1 -> res_id sequence 0,1,0,1 with one result per cycle.
- REQ-028 SHALL cover backpressure: res_ready=0 while FULL and both requesters valid -> both readys stay 0; res_out is unchanged for 5 cycles; releasing res_ready grants the pointer's requester.
- REQ-029 SHALL cover arithmetic wrap: op=100, x=0xFFFFFFFF, y=1 -> res_out=0; op=110, x=0x80000000, y=0 -> res_out=1; op=101, x=0, y=1 -> res_out=0xFFFFFFFF.
- REQ-030 SHALL cover reset mid-operation: rst=1 while FULL -> res_valid=0 and res_out=0 next cycle; the next contention after reset grants req0 first.
